// File: rtl/loop_filter_5bit_if.sv
`default_nettype none
// ============================================================================
// Module   : loop_filter_5bit_if
// Function : Phase-error sample bus into, and DCO control word out of, the
//            ADPLL loop filter.
// Revision : 1.0
// ============================================================================
interface loop_filter_5bit_if;
   logic       err_valid;
   logic       err_sign;
   logic [4:0] err;
   logic       ctrl_valid;
   logic       ctrl_sign;
   logic [4:0] ctrl;
   logic       locked;

   modport master (
      output err_valid, err_sign, err,
      input  ctrl_valid, ctrl_sign, ctrl, locked
   );

   modport slave (
      input  err_valid, err_sign, err,
      output ctrl_valid, ctrl_sign, ctrl, locked
   );
endinterface
`default_nettype wire

// File: rtl/loop_filter_5bit.sv
`default_nettype none
// ============================================================================
// Module   : loop_filter_5bit
// Function : Two-stage PI loop filter with saturating fractional integrator
//            and consecutive-sample lock detector.
// Revision : 1.0
// ============================================================================
module loop_filter_5bit #(
   parameter int LOCK_TOL = 2,
   parameter int LOCK_CNT = 16
) (
   input  wire logic       clk,
   input  wire logic       reset,
   input  wire logic [2:0] kp_shift,
   input  wire logic [2:0] ki_shift,
   input  wire logic       freeze,
   loop_filter_5bit_if.slave bus
);
   localparam logic [7:0]         c_lock_tol = 8'(LOCK_TOL);
   localparam logic [7:0]         c_lock_cnt = 8'(LOCK_CNT);
   localparam logic signed [12:0] c_acc_max  = 13'sd2047;
   localparam logic signed [12:0] c_acc_min  = -13'sd2047;

   logic signed [5:0]  p_d, p_q;
   logic signed [11:0] acc_d, acc_q;
   logic [7:0]         lock_cnt_d, lock_cnt_q;
   logic               v1_d, v1_q;
   logic               ctrl_sign_d, ctrl_sign_q;
   logic [4:0]         ctrl_d, ctrl_q;
   logic               ctrl_valid_d, ctrl_valid_q;
   logic               locked_d, locked_q;

   logic               e_neg;
   logic [4:0]         p_mag;
   logic [8:0]         inc_mag;
   logic signed [12:0] inc_s;
   logic signed [12:0] acc_sum;
   logic [10:0]        acc_abs;
   logic [6:0]         i_mag;
   logic signed [8:0]  i_val;
   logic signed [8:0]  y;
   logic signed [8:0]  y_abs;

   // Stage 1: proportional term, integrator and lock counter
   always_comb begin
      e_neg      = bus.err_sign & (bus.err != 5'd0);
      p_mag      = bus.err >> kp_shift;
      inc_mag    = {bus.err, 4'b0000} >> ki_shift;
      inc_s      = e_neg ? -$signed({4'b0000, inc_mag}) : $signed({4'b0000, inc_mag});
      acc_sum    = $signed({acc_q[11], acc_q}) + inc_s;
      p_d        = p_q;
      acc_d      = acc_q;
      lock_cnt_d = lock_cnt_q;
      v1_d       = bus.err_valid;
      if (bus.err_valid) begin
         p_d = e_neg ? -$signed({1'b0, p_mag}) : $signed({1'b0, p_mag});
         if (!freeze) begin
            if (acc_sum > c_acc_max)
               acc_d = 12'sd2047;
            else if (acc_sum < c_acc_min)
               acc_d = -12'sd2047;
            else
               acc_d = acc_sum[11:0];
         end
         if ({3'b000, bus.err} <= c_lock_tol)
            lock_cnt_d = (lock_cnt_q >= c_lock_cnt) ? lock_cnt_q : lock_cnt_q + 8'd1;
         else
            lock_cnt_d = 8'd0;
      end
   end

   // Stage 2: acc_q already holds this sample's updated integrator value
   always_comb begin
      acc_abs      = acc_q[11] ? (~acc_q[10:0] + 11'd1) : acc_q[10:0];
      i_mag        = 7'(acc_abs >> 4);
      i_val        = acc_q[11] ? -$signed({2'b00, i_mag}) : $signed({2'b00, i_mag});
      y            = $signed({{3{p_q[5]}}, p_q}) + i_val;
      y_abs        = y[8] ? -y : y;
      ctrl_valid_d = v1_q;
      ctrl_sign_d  = ctrl_sign_q;
      ctrl_d       = ctrl_q;
      locked_d     = locked_q;
      if (v1_q) begin
         ctrl_sign_d = ~y[8] & (y != 9'sd0);
         ctrl_d      = (y_abs > 9'sd31) ? 5'd31 : y_abs[4:0];
         locked_d    = (lock_cnt_q == c_lock_cnt);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_q          <= '0;
         acc_q        <= '0;
         lock_cnt_q   <= '0;
         v1_q         <= 1'b0;
         ctrl_sign_q  <= 1'b0;
         ctrl_q       <= '0;
         ctrl_valid_q <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         p_q          <= p_d;
         acc_q        <= acc_d;
         lock_cnt_q   <= lock_cnt_d;
         v1_q         <= v1_d;
         ctrl_sign_q  <= ctrl_sign_d;
         ctrl_q       <= ctrl_d;
         ctrl_valid_q <= ctrl_valid_d;
         locked_q     <= locked_d;
      end
   end

   assign bus.ctrl_valid = ctrl_valid_q;
   assign bus.ctrl_sign  = ctrl_sign_q;
   assign bus.ctrl       = ctrl_q;
   assign bus.locked     = locked_q;
endmodule
`default_nettype wire

// File: tb/tb_loop_filter_5bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_loop_filter_5bit
// Function : Directed and randomized checks of loop_filter_5bit against an
//            integer-arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_loop_filter_5bit;
   localparam int LOCK_TOL = 2;
   localparam int LOCK_CNT = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] kp_shift = '0;
   logic [2:0] ki_shift = '0;
   logic       freeze = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;

   loop_filter_5bit_if bus ();

   loop_filter_5bit #(.LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)) dut (
      .clk      (clk),
      .reset    (reset),
      .kp_shift (kp_shift),
      .ki_shift (ki_shift),
      .freeze   (freeze),
      .bus      (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: integrator in 1/16 units, result queued for two cycles
   int         m_acc, m_cnt;
   bit         pend_v, pend_s, pend_l;
   logic [4:0] pend_c;
   bit         exp_v, exp_s, exp_l;
   logic [4:0] exp_c;

   task automatic model_clear();
      m_acc = 0; m_cnt = 0;
      pend_v = 0; pend_s = 0; pend_c = '0; pend_l = 0;
      exp_v = 0; exp_s = 0; exp_c = '0; exp_l = 0;
   endtask

   task automatic model_accept(input int s, input int e, input int kp, input int ki, input bit frz);
      int sg, p, i, y, ay;
      sg = (s != 0) ? -1 : 1;
      p  = sg * (e >> kp);
      if (!frz) begin
         m_acc = m_acc + sg * ((e * 16) >> ki);
         if (m_acc > 2047) m_acc = 2047;
         if (m_acc < -2047) m_acc = -2047;
      end
      i  = (m_acc < 0) ? -((-m_acc) / 16) : (m_acc / 16);
      y  = p + i;
      ay = (y < 0) ? -y : y;
      pend_s = (y > 0);
      pend_c = 5'((ay > 31) ? 31 : ay);
      if (e <= LOCK_TOL) m_cnt = (m_cnt >= LOCK_CNT) ? LOCK_CNT : m_cnt + 1;
      else               m_cnt = 0;
      pend_l = (m_cnt == LOCK_CNT);
   endtask

   task automatic cycle(input bit v, input bit s, input int e, input int kp, input int ki, input bit frz);
      @(negedge clk);
      bus.err_valid = v;
      bus.err_sign  = s;
      bus.err       = 5'(e);
      kp_shift      = 3'(kp);
      ki_shift      = 3'(ki);
      freeze        = frz;
      @(posedge clk);
      #1;
      exp_v = pend_v;
      if (pend_v) begin
         exp_s = pend_s; exp_c = pend_c; exp_l = pend_l;
      end
      pend_v = v;
      if (v) model_accept(int'(s), e, kp, ki, frz);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      bus.err_valid = 1'b0;
      reset = 1'b1;
      #1;
      model_clear();
      n_checks++;
      if ({bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked} !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_async: got v=%0b s=%0b c=%0d l=%0b, expected all 0",
                  bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.err_valid = 1'b0; bus.err_sign = 1'b0; bus.err = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked} !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_state: got v=%0b s=%0b c=%0d l=%0b, expected all 0",
                  bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         cycle(k == 0, 1'b0, 8, 0, 7, 1'b0);
         n_checks++;
         if ({bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked} !== {exp_v, exp_s, exp_c, exp_l}) begin
            n_errors++;
            $display("FAIL basic[%0d]: got v=%0b s=%0b c=%0d l=%0b, expected v=%0b s=%0b c=%0d l=%0b",
                     k, bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked, exp_v, exp_s, exp_c, exp_l);
         end
         if (k == 1) begin
            n_checks++;
            if ({bus.ctrl_valid, bus.ctrl_sign, bus.ctrl} !== {1'b1, 1'b1, 5'd8}) begin
               n_errors++;
               $display("FAIL basic_value: got v=%0b s=%0b c=%0d, expected v=1 s=1 c=8",
                        bus.ctrl_valid, bus.ctrl_sign, bus.ctrl);
            end
         end
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         if (k < 5)       cycle(1'b1, 1'b1, 31, 0, 0, 1'b0);
         else if (k == 5) cycle(1'b1, 1'b0, 0, 0, 0, 1'b0);
         else             cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
         n_checks++;
         if ({bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked} !== {exp_v, exp_s, exp_c, exp_l}) begin
            n_errors++;
            $display("FAIL saturation[%0d]: got v=%0b s=%0b c=%0d l=%0b, expected v=%0b s=%0b c=%0d l=%0b",
                     k, bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked, exp_v, exp_s, exp_c, exp_l);
         end
      end
      n_checks++;
      if ({bus.ctrl_sign, bus.ctrl} !== {1'b0, 5'd31} || m_acc != -2047) begin
         n_errors++;
         $display("FAIL saturation_hold: got s=%0b c=%0d model_acc=%0d, expected s=0 c=31 acc=-2047",
                  bus.ctrl_sign, bus.ctrl, m_acc);
      end
   endtask

   task automatic test_zero();
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         case (k)
            0:       cycle(1'b1, 1'b1, 0, 0, 0, 1'b0);
            2:       cycle(1'b1, 1'b0, 7, 3, 7, 1'b0);
            default: cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
         endcase
         n_checks++;
         if ({bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked} !== {exp_v, exp_s, exp_c, exp_l}) begin
            n_errors++;
            $display("FAIL zero[%0d]: got v=%0b s=%0b c=%0d l=%0b, expected v=%0b s=%0b c=%0d l=%0b",
                     k, bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked, exp_v, exp_s, exp_c, exp_l);
         end
         if (k == 1 || k == 3) begin
            n_checks++;
            if ({bus.ctrl_valid, bus.ctrl_sign, bus.ctrl} !== {1'b1, 1'b0, 5'd0}) begin
               n_errors++;
               $display("FAIL zero_value[%0d]: got v=%0b s=%0b c=%0d, expected v=1 s=0 c=0",
                        k, bus.ctrl_valid, bus.ctrl_sign, bus.ctrl);
            end
         end
      end
   endtask

   task automatic test_freeze();
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         case (k)
            0:       cycle(1'b1, 1'b0, 10, 0, 0, 1'b0);
            1:       cycle(1'b1, 1'b1, 4, 0, 0, 1'b1);
            default: cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
         endcase
         n_checks++;
         if ({bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked} !== {exp_v, exp_s, exp_c, exp_l}) begin
            n_errors++;
            $display("FAIL freeze[%0d]: got v=%0b s=%0b c=%0d l=%0b, expected v=%0b s=%0b c=%0d l=%0b",
                     k, bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked, exp_v, exp_s, exp_c, exp_l);
         end
         if (k == 2) begin
            n_checks++;
            if ({bus.ctrl_valid, bus.ctrl_sign, bus.ctrl} !== {1'b1, 1'b1, 5'd6}) begin
               n_errors++;
               $display("FAIL freeze_value: got v=%0b s=%0b c=%0d, expected v=1 s=1 c=6",
                        bus.ctrl_valid, bus.ctrl_sign, bus.ctrl);
            end
         end
      end
   endtask

   task automatic test_lock();
      apply_reset();
      for (int k = 0; k < 19; k++) begin
         if (k < 16)       cycle(1'b1, 1'($urandom_range(0, 1)), 1, 0, 7, 1'b0);
         else if (k == 17) cycle(1'b1, 1'b0, 3, 0, 7, 1'b0);
         else              cycle(1'b0, 1'b0, 0, 0, 7, 1'b0);
         n_checks++;
         if ({bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked} !== {exp_v, exp_s, exp_c, exp_l}) begin
            n_errors++;
            $display("FAIL lock[%0d]: got v=%0b s=%0b c=%0d l=%0b, expected v=%0b s=%0b c=%0d l=%0b",
                     k, bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked, exp_v, exp_s, exp_c, exp_l);
         end
         if (k == 15 || k == 16 || k == 18) begin
            n_checks++;
            if ({bus.ctrl_valid, bus.locked} !== {1'b1, (k == 16)}) begin
               n_errors++;
               $display("FAIL lock_edge[%0d]: got v=%0b l=%0b, expected v=1 l=%0b",
                        k, bus.ctrl_valid, bus.locked, (k == 16));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      cycle(1'b1, 1'b0, 20, 0, 0, 1'b0);
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         if (k == 2) cycle(1'b1, 1'b0, 0, 0, 0, 1'b0);
         else        cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
         n_checks++;
         if ({bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked} !== {exp_v, exp_s, exp_c, exp_l}) begin
            n_errors++;
            $display("FAIL reset_mid[%0d]: got v=%0b s=%0b c=%0d l=%0b, expected v=%0b s=%0b c=%0d l=%0b",
                     k, bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked, exp_v, exp_s, exp_c, exp_l);
         end
         n_checks++;
         if ({bus.ctrl_valid, bus.ctrl_sign, bus.ctrl} !== {(k == 3), 1'b0, 5'd0}) begin
            n_errors++;
            $display("FAIL reset_mid_value[%0d]: got v=%0b s=%0b c=%0d, expected v=%0b s=0 c=0",
                     k, bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, (k == 3));
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int k = 0; k < 400; k++) begin
         cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               $urandom_range(0, 7) == 0);
         n_checks++;
         if ({bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked} !== {exp_v, exp_s, exp_c, exp_l}) begin
            n_errors++;
            $display("FAIL random[%0d]: got v=%0b s=%0b c=%0d l=%0b, expected v=%0b s=%0b c=%0d l=%0b",
                     k, bus.ctrl_valid, bus.ctrl_sign, bus.ctrl, bus.locked, exp_v, exp_s, exp_c, exp_l);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_zero();
      test_freeze();
      test_lock();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
